// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive peripheral and its future transmit
// sibling.
//   rx_state_e        receiver FSM state encoding
//   REG_RXDATA/STATUS register select values, as decoded from address[2]
//   ST_*              bit positions inside the STATUS word
//   status_word()     assembles the 32-bit STATUS read value
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam logic REG_RXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_FERR   = 3;

  function automatic logic [31:0] status_word(input logic ferr, input logic ovr,
                                              input logic full, input logic nempty);
    logic [31:0] w;
    w            = '0;
    w[ST_FERR]   = ferr;
    w[ST_OVR]    = ovr;
    w[ST_FULL]   = full;
    w[ST_NEMPTY] = nempty;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_periph_if.sv
// -----------------------------------------------------------------------------
// uart_bus_if
// DLX data-bus slot used by the UART peripheral.
//   chip_select, address, read_enable, write_enable, data_write : CPU -> periph
//   data_read, rdata_valid                                      : periph -> CPU
// Handshake: there is no back-pressure. A read is accepted in every cycle with
// chip_select && read_enable; its response appears on data_read with
// rdata_valid high for exactly the following cycle. A write is accepted in
// every cycle with chip_select && write_enable and has no response.
// -----------------------------------------------------------------------------
interface uart_bus_if;
  logic        chip_select;
  logic [31:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        rdata_valid;

  modport master (
    output chip_select, address, read_enable, write_enable, data_write,
    input  data_read, rdata_valid
  );

  modport slave (
    input  chip_select, address, read_enable, write_enable, data_write,
    output data_read, rdata_valid
  );
endinterface

// File: rtl/uart_rx_periph_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with wrap-bit pointers.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write request and data; ignored when full unless popping too
//   pop/rdata  : read request; rdata shows the head entry combinationally
//   full/empty : status derived directly from the pointers
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  // A pop frees the head slot in the same edge, so a full FIFO still accepts
  // a simultaneous push (the written slot is the one being vacated).
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_rx_periph.sv
// -----------------------------------------------------------------------------
// uart_rx_periph
// Memory-mapped 8N1 UART receiver with a receive FIFO.
//   clk, reset  : clock_50 domain, synchronous active-high reset
//   bus         : DLX data-bus slot (address[2]: 0 = RXDATA, 1 = STATUS)
//   rx          : asynchronous serial input, idles high
//   rx_pending  : high while the FIFO holds data
//   state_dbg   : current receiver FSM state
// RXDATA read pops the head byte (0 when empty). STATUS reads
// {ferr, overrun, full, nonempty}; writing 1s to bits 2/3 clears overrun/ferr.
// CLK_FREQ/BAUD must be at least 4.
// -----------------------------------------------------------------------------
module uart_rx_periph
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_bus_if.slave  bus,
  input  logic       rx,
  output logic       rx_pending,
  output rx_state_e  state_dbg
);
  localparam int          DIV         = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_RELOAD  = 16'(DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(DIV / 2 - 1);

  // rx synchroniser plus one more flop for falling-edge detection.
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Receiver FSM
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        push, ferr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state_q != IDLE && state_q != BREAK && cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            state_d = START;
            cnt_d   = HALF_RELOAD;
          end
        end
        START: begin
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_sync) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = BIT_RELOAD;
            bit_d   = 3'd0;
          end
        end
        DATA: begin
          shift_d = {rx_sync, shift_q[7:1]};
          cnt_d   = BIT_RELOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
        STOP: begin
          if (rx_sync) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end
        BREAK: begin
          if (rx_sync) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state_dbg = state_q;

  // FIFO and bus decode
  logic [7:0] fifo_head;
  logic       fifo_full, fifo_empty;
  logic       rd_acc, wr_status, pop, ovr_set;
  logic       ovr_q, ferr_q;

  assign rd_acc    = bus.chip_select & bus.read_enable;
  assign wr_status = bus.chip_select & bus.write_enable & (bus.address[2] == REG_STATUS);
  assign pop       = rd_acc & (bus.address[2] == REG_RXDATA);
  assign ovr_set   = push & fifo_full & ~pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (shift_q),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write-one-to-clear flags; a set in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_status & bus.data_write[ST_OVR]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_status & bus.data_write[ST_FERR]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_read   <= '0;
      bus.rdata_valid <= 1'b0;
      rx_pending      <= 1'b0;
    end else begin
      bus.rdata_valid <= rd_acc;
      rx_pending      <= ~fifo_empty;
      if (rd_acc) begin
        if (bus.address[2] == REG_STATUS)
          bus.data_read <= status_word(ferr_q, ovr_q, fifo_full, ~fifo_empty);
        else
          bus.data_read <= fifo_empty ? 32'd0 : {24'd0, fifo_head};
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.address[31:3], bus.address[1:0],
                         bus.data_write[31:4], bus.data_write[1:0]};
endmodule
